// File: rtl/cm_sketch_pkg.sv
// Shared constants and types for the count-min sketch hash front end.
// Seed reset values are derived from a fixed base and a golden-ratio step.
package cm_sketch_pkg;

  localparam logic [31:0] SEED_BASE = 32'h1689ADFC;
  localparam logic [31:0] SEED_STEP = 32'h9E3779B9;
  localparam int          MAX_ROWS  = 8;
  localparam int          MAX_ADDR  = 32;
  localparam int          N_STAGES  = 6;

  typedef struct packed {
    logic [2:0] row;
    logic [4:0] bit_idx;
  } seed_addr_t;

  function automatic logic [31:0] seed_default(int row, int bit_idx);
    logic [31:0] idx;
    idx = 32'(row * MAX_ADDR + bit_idx);
    return SEED_BASE ^ (idx * SEED_STEP);
  endfunction

endpackage

// File: rtl/cm_hash_bank_if.sv
// Request/result/seed-programming bundle of the multi-row hash bank.
// The master drives requests and seed writes; the slave is the hash bank.
interface cm_hash_bank_if
  import cm_sketch_pkg::*;
#(
  parameter int HASH_SIZE = 12,
  parameter int ADDR_SIZE = 22,
  parameter int D         = 4,
  parameter int TAG_W     = 8
);

  logic                         in_valid;
  logic                         in_ready;
  logic [ADDR_SIZE-1:0]         in_addr;
  logic [TAG_W-1:0]             in_tag;
  logic                         out_valid;
  logic                         out_ready;
  logic [D*HASH_SIZE-1:0]       out_hash;
  logic [TAG_W-1:0]             out_tag;
  logic                         seed_we;
  logic [$clog2(MAX_ROWS)-1:0]  seed_row;
  logic [$clog2(MAX_ADDR)-1:0]  seed_bit;
  logic [HASH_SIZE-1:0]         seed_data;
  logic [2:0]                   in_flight;

  modport master (
    output in_valid, in_addr, in_tag, out_ready,
           seed_we, seed_row, seed_bit, seed_data,
    input  in_ready, out_valid, out_hash, out_tag, in_flight
  );

  modport slave (
    input  in_valid, in_addr, in_tag, out_ready,
           seed_we, seed_row, seed_bit, seed_data,
    output in_ready, out_valid, out_hash, out_tag, in_flight
  );

endinterface

// File: rtl/cm_hash_xor_tree.sv
// One sketch row: registered 32 masked seed terms followed by five
// pipelined XOR reduction levels, all sharing a single stage enable.
module cm_hash_xor_tree
  import cm_sketch_pkg::*;
#(
  parameter int HASH_SIZE = 12
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_en,
  input  logic [MAX_ADDR-1:0][HASH_SIZE-1:0]   i_terms,
  output logic [HASH_SIZE-1:0]                 o_hash
);

  logic [31:0][HASH_SIZE-1:0] r_s0;
  logic [15:0][HASH_SIZE-1:0] r_s1;
  logic [7:0][HASH_SIZE-1:0]  r_s2;
  logic [3:0][HASH_SIZE-1:0]  r_s3;
  logic [1:0][HASH_SIZE-1:0]  r_s4;
  logic [HASH_SIZE-1:0]       r_s5;

  // NOTE: non-blocking assignments make every level read the previous
  // edge's contents of the level before it, which is what forms the pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s0 <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
      r_s4 <= '0;
      r_s5 <= '0;
    end else if (i_en) begin
      r_s0 <= i_terms;
      for (int k = 0; k < 16; k++) r_s1[k] <= r_s0[2*k] ^ r_s0[2*k+1];
      for (int k = 0; k < 8; k++)  r_s2[k] <= r_s1[2*k] ^ r_s1[2*k+1];
      for (int k = 0; k < 4; k++)  r_s3[k] <= r_s2[2*k] ^ r_s2[2*k+1];
      for (int k = 0; k < 2; k++)  r_s4[k] <= r_s3[2*k] ^ r_s3[2*k+1];
      r_s5 <= r_s4[0] ^ r_s4[1];
    end
  end

  assign o_hash = r_s5;

endmodule

// File: rtl/cm_hash_bank.sv
// D-row H3 hash bank: programmable seed table, per-row XOR pipelines,
// valid/tag shift chain with a single global advance for backpressure.
module cm_hash_bank
  import cm_sketch_pkg::*;
#(
  parameter int W         = 4096,
  parameter int HASH_SIZE = $clog2(W),
  parameter int ADDR_SIZE = 22,
  parameter int D         = 4,
  parameter int TAG_W     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  cm_hash_bank_if.slave  bus
);

  logic                              w_adv;
  logic [N_STAGES-1:0]               r_valid;
  logic [TAG_W-1:0]                  r_tag [N_STAGES];
  logic [HASH_SIZE-1:0]              r_seed [D][MAX_ADDR];
  logic [MAX_ADDR-1:0]               w_addr;
  logic [MAX_ADDR-1:0][HASH_SIZE-1:0] w_terms [D];
  logic [D-1:0][HASH_SIZE-1:0]       w_hash;
  seed_addr_t                        w_seed_addr;

  // Every stage moves together; a stalled result freezes the whole bank.
  assign w_adv       = !r_valid[N_STAGES-1] || bus.out_ready;
  assign w_addr      = MAX_ADDR'(bus.in_addr);
  assign w_seed_addr = '{row: bus.seed_row, bit_idx: bus.seed_bit};

  // NOTE: the seed table is reset explicitly because its default contents
  // define the hash functions seen right after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < D; d++)
        for (int i = 0; i < MAX_ADDR; i++)
          r_seed[d][i] <= (i < ADDR_SIZE) ? HASH_SIZE'(seed_default(d, i)) : '0;
    end else if (bus.seed_we) begin
      for (int d = 0; d < D; d++)
        for (int i = 0; i < ADDR_SIZE; i++)
          if (int'(w_seed_addr.row) == d && int'(w_seed_addr.bit_idx) == i)
            r_seed[d][i] <= bus.seed_data;
    end
  end

  // NOTE: every element is assigned on every pass, so no latch is inferred.
  always_comb begin
    for (int d = 0; d < D; d++)
      for (int i = 0; i < MAX_ADDR; i++)
        w_terms[d][i] = w_addr[i] ? r_seed[d][i] : '0;
  end

  for (genvar d = 0; d < D; d++) begin : g_row
    cm_hash_xor_tree #(.HASH_SIZE(HASH_SIZE)) u_tree (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_adv),
      .i_terms (w_terms[d]),
      .o_hash  (w_hash[d])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int s = 0; s < N_STAGES; s++) r_tag[s] <= '0;
    end else if (w_adv) begin
      r_valid  <= {r_valid[N_STAGES-2:0], bus.in_valid};
      r_tag[0] <= bus.in_tag;
      for (int s = 1; s < N_STAGES; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_valid[N_STAGES-1];
  assign bus.out_tag   = r_tag[N_STAGES-1];
  assign bus.out_hash  = w_hash;
  assign bus.in_flight = 3'($countones(r_valid));

endmodule

// File: tb/tb_cm_hash_bank.sv
// Self-checking bench for cm_hash_bank: a queue-based reference model checked
// every cycle, directed scenarios with literal expectations, and random traffic.
module tb_cm_hash_bank;
  import cm_sketch_pkg::*;

  localparam int W  = 4096;
  localparam int HS = 12;
  localparam int AS = 22;
  localparam int D  = 4;
  localparam int TW = 8;
  localparam int HW = D * HS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cm_hash_bank_if #(.HASH_SIZE(HS), .ADDR_SIZE(AS), .D(D), .TAG_W(TW)) bus ();

  cm_hash_bank #(.W(W), .HASH_SIZE(HS), .ADDR_SIZE(AS), .D(D), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [HW-1:0] h;
    logic [TW-1:0] tag;
    int            age;
  } item_t;

  logic [HS-1:0] m_seed [D][32];
  item_t         m_q [$];
  int            n_pops = 0;
  bit            live   = 1'b0;

  function automatic logic [HS-1:0] spec_seed(int d, int i);
    logic [31:0] v;
    v = 32'h1689ADFC ^ (32'(d * 32 + i) * 32'h9E3779B9);
    return (i < AS) ? v[HS-1:0] : '0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < D; d++)
      for (int i = 0; i < 32; i++)
        m_seed[d][i] = spec_seed(d, i);
    m_q.delete();
  endtask

  function automatic logic [HW-1:0] model_hash(logic [31:0] a);
    logic [HW-1:0] h;
    h = '0;
    for (int d = 0; d < D; d++)
      for (int i = 0; i < AS; i++)
        if (a[i]) h[d*HS +: HS] ^= m_seed[d][i];
    return h;
  endfunction

  function automatic logic [HS-1:0] row_of(logic [HW-1:0] h, int d);
    return h[d*HS +: HS];
  endfunction

  // Items age once per advancing edge; the oldest is visible at age 6.
  always @(negedge clk) begin : mon
    logic  exp_valid;
    logic  adv;
    item_t it;
    int    r;
    int    b;
    exp_valid = (m_q.size() > 0) && (m_q[0].age == N_STAGES);
    if (live) begin
      check("out_valid", bus.out_valid, exp_valid);
      check("in_flight", bus.in_flight, m_q.size());
      check("in_ready", bus.in_ready, !exp_valid || bus.out_ready);
      if (exp_valid && bus.out_valid) begin
        check("out_hash", bus.out_hash, m_q[0].h);
        check("out_tag", bus.out_tag, m_q[0].tag);
      end
    end
    if (!rst_n) begin
      model_reset();
      live = 1'b1;
    end else if (live) begin
      adv = !exp_valid || bus.out_ready;
      if (adv) begin
        if (exp_valid) begin
          void'(m_q.pop_front());
          n_pops++;
        end
        foreach (m_q[k]) m_q[k].age++;
        if (bus.in_valid) begin
          it.h   = model_hash(32'(bus.in_addr));
          it.tag = bus.in_tag;
          it.age = 1;
          m_q.push_back(it);
        end
      end
      r = int'(bus.seed_row);
      b = int'(bus.seed_bit);
      if (bus.seed_we && r < D && b < AS) m_seed[r][b] = bus.seed_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] a, logic [TW-1:0] t);
    bit acc;
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_addr  = AS'(a);
    bus.in_tag   = t;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      guard++;
    end while (!acc && guard < 100);
    check("send_accepted", acc, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(output logic [HW-1:0] h, output logic [TW-1:0] t, output int lat);
    bit found;
    found = 1'b0;
    lat   = 1;
    h     = '0;
    t     = '0;
    while (!found && lat < 60) begin
      @(negedge clk);
      if (bus.out_valid) begin
        h     = bus.out_hash;
        t     = bus.out_tag;
        found = 1'b1;
      end
      tick();
      if (!found) lat++;
    end
    check("result_arrived", found, 1'b1);
  endtask

  task automatic seed_write(int r, int b, logic [HS-1:0] data);
    bus.seed_we   = 1'b1;
    bus.seed_row  = 3'(r);
    bus.seed_bit  = 5'(b);
    bus.seed_data = data;
    tick();
    bus.seed_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed + random scenarios ----------------
  initial begin
    logic [HW-1:0] h, cap_h;
    logic [TW-1:0] t, cap_t;
    int            lat;
    int            n0;
    int            sent;
    bit            acc;
    bit            stall;

    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    bus.seed_we   = 1'b0;
    bus.seed_row  = '0;
    bus.seed_bit  = '0;
    bus.seed_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_hash", bus.out_hash, '0);
    check("rst_out_tag", bus.out_tag, '0);
    check("rst_in_flight", bus.in_flight, 3'd0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("model_seed_0_0", m_seed[0][0], 12'hDFC);
    check("model_seed_1_0", m_seed[1][0], 12'hADC);
    check("model_seed_2_1", m_seed[2][1], 12'hA05);
    tick();

    // Default seeds, latency
    send(32'h1, 8'h11);
    get_result(h, t, lat);
    check("dflt_row0", row_of(h, 0), 12'hDFC);
    check("dflt_row1", row_of(h, 1), 12'hADC);
    check("dflt_tag", t, 8'h11);
    check("dflt_latency", lat, 6);

    // Seed programming and ignored writes
    seed_write(0, 0, 12'h123);
    seed_write(0, 3, 12'h0F0);
    seed_write(0, 25, 12'hABC);
    seed_write(5, 0, 12'hABC);
    send(32'h9, 8'h21);
    get_result(h, t, lat);
    check("prog_row0", row_of(h, 0), 12'h1D3);
    send(32'h2000009, 8'h22);
    get_result(h, t, lat);
    check("prog_row0_hibit", row_of(h, 0), 12'h1D3);

    // Streaming: 20 back-to-back, in-order results on consecutive cycles
    for (int j = 0; j < 27; j++) begin
      bus.in_valid = (j < 20);
      bus.in_addr  = AS'($urandom);
      bus.in_tag   = TW'(j);
      @(negedge clk);
      check("stream_in_ready", bus.in_ready, 1'b1);
      if (j >= 6 && j <= 25) begin
        check("stream_valid", bus.out_valid, 1'b1);
        check("stream_tag", bus.out_tag, TW'(j - 6));
      end
      if (j >= 6 && j <= 20) check("stream_in_flight", bus.in_flight, 3'd6);
      tick();
    end
    bus.in_valid = 1'b0;

    // Backpressure: 5-cycle stall mid-stream
    n0    = n_pops;
    sent  = 0;
    cap_h = '0;
    cap_t = '0;
    for (int j = 0; j < 40; j++) begin
      stall         = (j >= 8 && j < 13);
      bus.out_ready = !stall;
      bus.in_valid  = (sent < 15);
      bus.in_addr   = AS'($urandom);
      bus.in_tag    = TW'(8'h40 + sent);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (stall) begin
        check("bp_in_ready", bus.in_ready, 1'b0);
        if (j == 8) begin
          check("bp_valid", bus.out_valid, 1'b1);
          cap_h = bus.out_hash;
          cap_t = bus.out_tag;
        end else begin
          check("bp_hash_stable", bus.out_hash, cap_h);
          check("bp_tag_stable", bus.out_tag, cap_t);
        end
      end
      tick();
      if (acc) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_sent", sent, 15);
    check("bp_delivered", n_pops - n0, 15);

    // Seed write in the same cycle as an accepted input
    bus.seed_we   = 1'b1;
    bus.seed_row  = 3'd2;
    bus.seed_bit  = 5'd1;
    bus.seed_data = 12'hFFF;
    send(32'h2, 8'h61);
    bus.seed_we = 1'b0;
    get_result(h, t, lat);
    check("coh_old_seed", row_of(h, 2), 12'hA05);
    send(32'h2, 8'h62);
    get_result(h, t, lat);
    check("coh_new_seed", row_of(h, 2), 12'hFFF);

    // Random traffic with random seed writes
    for (int j = 0; j < 300; j++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_addr   = AS'($urandom);
      bus.in_tag    = TW'($urandom);
      bus.out_ready = ($urandom % 3) != 0;
      bus.seed_we   = ($urandom % 8) == 0;
      bus.seed_row  = 3'($urandom);
      bus.seed_bit  = 5'($urandom);
      bus.seed_data = HS'($urandom);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.seed_we   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) tick();

    // Reset during a stall with 4 results in flight
    seed_write(0, 0, 12'h555);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send($urandom, TW'(8'h70 + k));
    repeat (4) tick();
    @(negedge clk);
    check("stall_in_flight", bus.in_flight, 3'd4);
    check("stall_valid", bus.out_valid, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2_out_valid", bus.out_valid, 1'b0);
    check("rst2_in_flight", bus.in_flight, 3'd0);
    check("rst2_out_hash", bus.out_hash, '0);
    tick();
    bus.out_ready = 1'b1;
    send(32'h1, 8'h77);
    get_result(h, t, lat);
    check("rst2_row0", row_of(h, 0), 12'hDFC);
    check("rst2_row1", row_of(h, 1), 12'hADC);
    check("rst2_tag", t, 8'h77);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
